// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared widths and types for the SIMD AES vector datapath
package vector_pkg;

  localparam int VEC_W     = 128;
  localparam int LANE_W    = 32;
  localparam int NUM_LANES = VEC_W / LANE_W;

  typedef logic [VEC_W-1:0]  vec_t;
  typedef logic [LANE_W-1:0] lane_t;

  localparam vec_t VEC_ZERO = '0;

endpackage

// File: rtl/vector_register_reg_lane.sv
// rtl/vector_register_reg_lane.sv - one lane of the vector register: async-reset enabled flop group
module reg_lane #(
  parameter int            W         = 32,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/vector_register.sv
// rtl/vector_register.sv - N-bit lane-structured storage register
// Optional write-through bypass: define VECTOR_REGISTER_BYPASS_EN.
module vector_register
  import vector_pkg::*;
#(
  parameter int           N         = VEC_W,
  parameter int           LANE_W    = vector_pkg::LANE_W,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] writeData,
  input  logic         writeEn,
  output logic [N-1:0] read
);

  localparam int LANES = (LANE_W > 0) ? (N / LANE_W) : 0;

  if (N <= 0 || LANE_W <= 0 || (N % LANE_W) != 0) begin : g_bad_width
    $fatal(1, "vector_register: N must be a positive multiple of LANE_W");
  end

  logic [N-1:0] stored;

  // Every lane sees the same enable so a write is always the whole vector.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    reg_lane #(
      .W         (LANE_W),
      .RESET_VAL (RESET_VAL[k*LANE_W +: LANE_W])
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (writeEn),
      .d   (writeData[k*LANE_W +: LANE_W]),
      .q   (stored[k*LANE_W +: LANE_W])
    );
  end

`ifdef VECTOR_REGISTER_BYPASS_EN
  // Reset overrides the bypass so consumers never see data during reset.
  always_comb begin
    read = stored;
    if (rst) begin
      read = RESET_VAL;
    end else if (writeEn) begin
      read = writeData;
    end
  end
`else
  assign read = stored;
`endif

endmodule

// File: tb/tb_vector_register.sv
// tb/tb_vector_register.sv - randomized scoreboard bench for vector_register
module tb_vector_register;

`ifdef VECTOR_REGISTER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [127:0] writeData;
  logic         writeEn;
  logic [127:0] read;

  vector_register dut (
    .clk       (clk),
    .rst       (rst),
    .writeData (writeData),
    .writeEn   (writeEn),
    .read      (read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] exp_q [$];
  logic [127:0] mask_q [$];
  string        name_q [$];
  event         sample_ev;
  int           n_cmp;
  int           n_bad;

  logic [127:0] model;

  localparam logic [127:0] ALL  = {128{1'b1}};
  localparam logic [127:0] LANE0 = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
  localparam logic [127:0] LANE3 = 128'hFFFF_FFFF_0000_0000_0000_0000_0000_0000;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        logic [127:0] e;
        logic [127:0] m;
        string        nm;
        e  = exp_q.pop_front();
        m  = mask_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if ((read & m) !== (e & m)) begin
          n_bad++;
          $display("FAIL %s: read=%h expected=%h (mask %h) at %0t", nm, read & m, e & m, m, $time);
        end
      end
    end
  end

  task automatic chk(input logic [127:0] e, input logic [127:0] m, input string nm);
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(nm);
    ->sample_ev;
    #1;
  endtask

  function automatic logic [127:0] pre_edge(input logic r, input logic we, input logic [127:0] d);
    if (r) return '0;
    if (BYP && we) return d;
    return model;
  endfunction

  task automatic cycle(input logic r, input logic we, input logic [127:0] d, input string nm);
    @(negedge clk);
    rst = r;
    writeEn = we;
    writeData = d;
    #1;
    chk(pre_edge(r, we, d), ALL, {nm, "_pre"});
    @(posedge clk);
    if (r) model = '0;
    else if (we) model = d;
    #1;
    chk(model, ALL, nm);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] DEAD  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] BASIC = 128'h12345678_90ABCDEF_11223344_55667788;
  localparam logic [127:0] OVW   = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
  localparam logic [127:0] A5    = {16{8'hA5}};
  localparam logic [127:0] COF   = 128'hC0FFEE00_C0FFEE11_C0FFEE22_C0FFEE33;

  initial begin
    model     = '0;
    rst       = 1'b1;
    writeEn   = 1'b1;
    writeData = DEAD;
    #1;
    chk(128'h0, ALL, "rst_async");
    n_cmp++;
    if (read !== 128'h0) begin
      n_bad++;
      $display("FAIL rst_async_direct: read=%h at %0t", read, $time);
    end
    @(posedge clk);
    #1;
    chk(128'h0, ALL, "rst_hold_edge");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(BYP ? DEAD : 128'h0, ALL, "rst_release");
    @(posedge clk);
    model = DEAD;
    #1;
    chk(DEAD, ALL, "first_write");
    n_cmp++;
    if (read !== DEAD) begin
      n_bad++;
      $display("FAIL first_write_direct: read=%h at %0t", read, $time);
    end

    cycle(1'b0, 1'b1, BASIC, "basic");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 128'h0, "basic_hold");

    cycle(1'b0, 1'b1, OVW, "overwrite");
    chk(128'h0, LANE0, "lane0");
    chk(ALL, LANE3, "lane3");
    n_cmp++;
    if (read !== OVW) begin
      n_bad++;
      $display("FAIL overwrite_direct: read=%h at %0t", read, $time);
    end
    n_cmp++;
    if (read[31:0] !== 32'h0) begin
      n_bad++;
      $display("FAIL lane0_direct: lane0=%h at %0t", read[31:0], $time);
    end
    n_cmp++;
    if (read[127:96] !== 32'hFFFFFFFF) begin
      n_bad++;
      $display("FAIL lane3_direct: lane3=%h at %0t", read[127:96], $time);
    end
    cycle(1'b0, 1'b0, rnd128(), "ovw_hold");

    cycle(1'b0, 1'b1, 128'h1, "b2b_1");
    cycle(1'b0, 1'b1, 128'h2, "b2b_2");
    cycle(1'b0, 1'b1, 128'h3, "b2b_3");
    n_cmp++;
    if (read !== 128'h3) begin
      n_bad++;
      $display("FAIL b2b_direct: read=%h at %0t", read, $time);
    end

    cycle(1'b0, 1'b1, ALL, "all_ones");
    @(negedge clk);
    writeEn   = 1'b1;
    writeData = COF;
    rst       = 1'b1;
    model     = '0;
    #1;
    chk(128'h0, ALL, "rst_mid");
    n_cmp++;
    if (read !== 128'h0) begin
      n_bad++;
      $display("FAIL rst_mid_direct: read=%h at %0t", read, $time);
    end
    rst = 1'b0;
    #1;
    chk(BYP ? COF : 128'h0, ALL, "rst_mid_rel");
    @(posedge clk);
    model = COF;
    #1;
    chk(COF, ALL, "rst_mid_load");
    n_cmp++;
    if (read !== COF) begin
      n_bad++;
      $display("FAIL rst_mid_load_direct: read=%h at %0t", read, $time);
    end

    cycle(1'b1, 1'b1, DEAD, "rst_wins_edge");
    cycle(1'b0, 1'b1, A5, "bypass");

    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(15) == 0), $urandom_range(1), rnd128(), "rand");
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad != 0) begin
      $display("FAIL: %0d mismatches", n_bad);
    end else begin
      $display("PASS");
    end
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
